// File: rtl/extbus_master_6502.sv
// rtl/extbus_master_6502.sv - 6502-style external bus master with generated PHI2 clock
//
// Turns single-beat register requests into 6502-style bus cycles. Each access
// starts on a PHI2 falling edge. It holds chip select for one PHI2 cycle and
// samples the data bus in the last bm_clk cycle of PHI2 high. It then
// completes with a one-cycle rsp_valid pulse.
//
// Optional feature macro: EXTBUS_MASTER_RDY_EN
//   defined   - a low extbus_rdy at the sample point stretches the access by
//               whole PHI2 cycles. After MAX_WAIT stretches the access is
//               aborted and reported with rsp_timeout.
//   undefined - extbus_rdy is ignored, every access is one PHI2 cycle and
//               rsp_timeout is 0.
//
// Parameters:
//   PHASE_CYCLES  bm_clk cycles per PHI2 half-phase (2..255)
//   MAX_WAIT      maximum RDY-stretched PHI2 cycles per access (1..255)
//
// Ports:
//   bm_clk, bm_reset            clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_write/addr/wrdata       request fields, latched on acceptance
//   rsp_valid                   one-cycle completion pulse
//   rsp_rddata/rsp_timeout      completion results, held until next completion
//   extbus_phy2                 generated PHI2 bus clock
//   extbus_cs_n/rw_n/a/d        bus chip select, direction, address, data
//   extbus_rdy                  target ready (pulled up externally)
//   extbus_irq_n                open-drain interrupt from the target
//   irq                         synchronized active-high interrupt
module extbus_master_6502 #(
  parameter int PHASE_CYCLES = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic       bm_clk,
  input  logic       bm_reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wrdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rddata,
  output logic       rsp_timeout,
  output logic       extbus_phy2,
  output logic       extbus_cs_n,
  output logic       extbus_rw_n,
  output logic [2:0] extbus_a,
  inout  wire  [7:0] extbus_d,
  input  logic       extbus_rdy,
  input  logic       extbus_irq_n,
  output logic       irq
);

  localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_ACTIVE} state_t;

  state_t     state;
  logic [7:0] phase_cnt;
  logic       wr_q;
  logic [2:0] addr_q;
  logic [7:0] wdata_q;
  logic       irq_meta;
  logic       phase_last;
  logic       fall_tick;
  logic       rdy_ok;

  assign phase_last = (phase_cnt == PHASE_LAST);
  // Last cycle of PHI2 high. This is the sample point, and the next edge is the PHI2 fall.
  assign fall_tick  = phase_last && extbus_phy2;

`ifdef EXTBUS_MASTER_RDY_EN
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT);
  logic [7:0] wait_cnt;
  logic       timeout_q;
  assign rdy_ok      = extbus_rdy;
  assign rsp_timeout = timeout_q;
`else
  // Ready is treated as permanently high; the OR keeps both inputs referenced.
  assign rdy_ok      = extbus_rdy | (MAX_WAIT > 0);
  assign rsp_timeout = 1'b0;
`endif

  // Only an active write owns the data bus.
  assign extbus_d = (state == ST_ACTIVE && wr_q) ? wdata_q : 8'hzz;

  always_ff @(posedge bm_clk) begin
    if (bm_reset) begin
      state       <= ST_IDLE;
      phase_cnt   <= 8'd0;
      extbus_phy2 <= 1'b0;
      extbus_cs_n <= 1'b1;
      extbus_rw_n <= 1'b1;
      extbus_a    <= 3'd0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rddata  <= 8'd0;
      irq_meta    <= 1'b0;
      irq         <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 3'd0;
      wdata_q     <= 8'd0;
`ifdef EXTBUS_MASTER_RDY_EN
      wait_cnt    <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      phase_cnt <= phase_last ? 8'd0 : phase_cnt + 8'd1;
      if (phase_last) begin
        extbus_phy2 <= ~extbus_phy2;
      end
      irq_meta  <= ~extbus_irq_n;
      irq       <= irq_meta;
      rsp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wrdata;
            req_ready <= 1'b0;
            state     <= ST_PENDING;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_PENDING: begin
          if (fall_tick) begin
            state       <= ST_ACTIVE;
            extbus_cs_n <= 1'b0;
            extbus_rw_n <= ~wr_q;
            extbus_a    <= addr_q;
`ifdef EXTBUS_MASTER_RDY_EN
            wait_cnt    <= 8'd0;
`endif
          end
        end

        ST_ACTIVE: begin
          if (fall_tick) begin
            if (rdy_ok) begin
              state       <= ST_IDLE;
              extbus_cs_n <= 1'b1;
              extbus_rw_n <= 1'b1;
              rsp_valid   <= 1'b1;
              req_ready   <= 1'b1;
              rsp_rddata  <= wr_q ? 8'd0 : extbus_d;
`ifdef EXTBUS_MASTER_RDY_EN
              timeout_q   <= 1'b0;
            end else if (wait_cnt == WAIT_LAST) begin
              state       <= ST_IDLE;
              extbus_cs_n <= 1'b1;
              extbus_rw_n <= 1'b1;
              rsp_valid   <= 1'b1;
              req_ready   <= 1'b1;
              rsp_rddata  <= 8'd0;
              timeout_q   <= 1'b1;
            end else begin
              wait_cnt    <= wait_cnt + 8'd1;
`endif
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extbus_master_6502.sv
// tb/tb_extbus_master_6502.sv - directed plus randomized bench for extbus_master_6502
module tb_extbus_master_6502;

  localparam int P   = 2;
  localparam int MW  = 3;
  localparam int PER = 2 * P;
`ifdef EXTBUS_MASTER_RDY_EN
  localparam bit RDY_EN = 1'b1;
`else
  localparam bit RDY_EN = 1'b0;
`endif

  logic       bm_clk = 1'b0;
  logic       bm_reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wrdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_rddata;
  logic       rsp_timeout;
  logic       extbus_phy2;
  logic       extbus_cs_n;
  logic       extbus_rw_n;
  logic [2:0] extbus_a;
  wire  [7:0] extbus_d;
  logic       extbus_rdy = 1'b1;
  logic       extbus_irq_n = 1'b1;
  logic       irq;

  logic       tgt_en = 1'b0;
  logic [7:0] tgt_data = 8'd0;

  assign extbus_d = tgt_en ? tgt_data : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (extbus_d[gi]);
  end

  always #5 bm_clk = ~bm_clk;

  extbus_master_6502 #(.PHASE_CYCLES(P), .MAX_WAIT(MW)) dut (
    .bm_clk(bm_clk), .bm_reset(bm_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata), .rsp_timeout(rsp_timeout),
    .extbus_phy2(extbus_phy2), .extbus_cs_n(extbus_cs_n), .extbus_rw_n(extbus_rw_n),
    .extbus_a(extbus_a), .extbus_d(extbus_d), .extbus_rdy(extbus_rdy),
    .extbus_irq_n(extbus_irq_n), .irq(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one outstanding access, described by its key cycle numbers.
  int         cyc = 0;
  bit         in_reset = 1'b1;
  bit         irq_rand_en = 1'b0;
  bit         live = 1'b0;
  int         n_acc = 0;
  int         t_start = 0;
  int         t_rsp = 0;
  int         low_cnt = 0;
  bit         m_wr = 1'b0;
  logic [2:0] m_addr = 3'd0;
  logic [7:0] m_data = 8'd0;
  bit         m_to = 1'b0;
  logic [7:0] held_rd = 8'd0;
  logic       held_to = 1'b0;
  logic [2:0] a_hold = 3'd0;
  logic       h0 = 1'b1;
  logic       h1 = 1'b1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit in_win;
    @(posedge bm_clk);
    #1;
    if (in_reset) begin
      chk("rst_cs_n", 8'(extbus_cs_n), 8'd1);
      chk("rst_rw_n", 8'(extbus_rw_n), 8'd1);
      chk("rst_addr", 8'(extbus_a), 8'd0);
      chk("rst_phy2", 8'(extbus_phy2), 8'd0);
      chk("rst_ready", 8'(req_ready), 8'd0);
      chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
      chk("rst_rddata", rsp_rddata, 8'd0);
      chk("rst_timeout", 8'(rsp_timeout), 8'd0);
      chk("rst_irq", 8'(irq), 8'd0);
      chk("rst_data", extbus_d, 8'hff);
    end else begin
      cyc++;
      h1 = h0;
      h0 = extbus_irq_n;
      if (irq_rand_en && $urandom_range(0, 5) == 0) extbus_irq_n = ~extbus_irq_n;
      in_win = live && cyc >= t_start && cyc < t_rsp;
      extbus_rdy = !(in_win && ((cyc - t_start) / PER) < low_cnt);
      tgt_en = in_win && !m_wr;
      tgt_data = m_data;
      if (live && cyc == t_start) a_hold = m_addr;
      if (live && cyc == t_rsp) begin
        held_rd = (m_wr || m_to) ? 8'd0 : m_data;
        held_to = m_to;
      end
      #1;
      chk("phy2", 8'(extbus_phy2), 8'(((cyc / P) % 2) == 1));
      chk("cs_n", 8'(extbus_cs_n), 8'(!in_win));
      chk("rw_n", 8'(extbus_rw_n), 8'(in_win ? !m_wr : 1'b1));
      chk("addr", 8'(extbus_a), 8'(a_hold));
      chk("rsp_valid", 8'(rsp_valid), 8'(live && cyc == t_rsp));
      chk("rddata", rsp_rddata, held_rd);
      chk("timeout", 8'(rsp_timeout), 8'(held_to));
      chk("req_ready", 8'(req_ready), 8'(!(live && cyc > n_acc && cyc < t_rsp)));
      chk("irq", 8'(irq), 8'(!h1));
      chk("data", extbus_d, in_win ? m_data : 8'hff);
      if (live && cyc == t_rsp) live = 1'b0;
    end
  endtask

  task automatic start_access(input bit wr, input logic [2:0] addr, input logic [7:0] data,
                              input int low, input int delay);
    int f;
    int k;
    int guard;
    repeat (delay) tick();
    req_valid = 1'b1;
    req_write = wr;
    req_addr = addr;
    req_wrdata = data;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $error("FAIL accept_wait cyc=%0d observed=req_ready_low expected=accept", cyc);
      req_valid = 1'b0;
      return;
    end
    // Accepted at the edge ending this cycle; the access starts after the next PHI2 fall.
    n_acc = cyc;
    f = n_acc + 1;
    while (f % PER != PER - 1) f++;
    t_start = f + 1;
    if (RDY_EN) begin
      if (low <= MW) begin
        k = low + 1;
        m_to = 1'b0;
      end else begin
        k = MW + 1;
        m_to = 1'b1;
      end
    end else begin
      k = 1;
      m_to = 1'b0;
    end
    t_rsp = t_start + PER * k;
    low_cnt = low;
    m_wr = wr;
    m_addr = addr;
    m_data = data;
    live = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_access();
    while (live) tick();
  endtask

  task automatic do_access(input bit wr, input logic [2:0] addr, input logic [7:0] data,
                           input int low, input int delay);
    start_access(wr, addr, data, low, delay);
    finish_access();
  endtask

  task automatic do_reset(input int n);
    bm_reset = 1'b1;
    in_reset = 1'b1;
    live = 1'b0;
    tgt_en = 1'b0;
    req_valid = 1'b0;
    extbus_rdy = 1'b1;
    repeat (n) tick();
    bm_reset = 1'b0;
    in_reset = 1'b0;
    cyc = 0;
    held_rd = 8'd0;
    held_to = 1'b0;
    a_hold = 3'd0;
    h0 = 1'b1;
    h1 = 1'b1;
  endtask

  initial begin
    do_reset(3);

    do_access(1'b1, 3'd3, 8'hA5, 0, 0);
    do_access(1'b0, 3'd7, 8'h5A, 0, 1);
    do_access(1'b0, 3'd2, 8'($urandom_range(0, 254)), 2, 0);
    do_access(1'b0, 3'd5, 8'($urandom_range(0, 254)), 50, 2);
    do_access(1'b1, 3'd1, 8'($urandom_range(0, 254)), MW, 0);
    do_access(1'b0, 3'd6, 8'($urandom_range(0, 254)), MW + 1, 0);
    do_access(1'b0, 3'd4, 8'h3C, 0, 0);

    extbus_irq_n = 1'b0;
    repeat (4) tick();
    extbus_irq_n = 1'b1;
    repeat (4) tick();

    irq_rand_en = 1'b1;
    do_access(1'b1, 3'd0, 8'h11, 0, 0);
    do_access(1'b0, 3'd7, 8'h22, 0, 0);
    do_access(1'b1, 3'd5, 8'h33, 1, 0);

    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 254)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, PER)));
    end

    irq_rand_en = 1'b0;
    start_access(1'b1, 3'd4, 8'h3C, 0, 0);
    while (cyc < t_start + 1) tick();
    do_reset(2);
    do_access(1'b0, 3'd2, 8'h96, 1, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
